alu_cmd_sequencer: RTL

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer_if.sv | 27 ++
 rtl/alu_cmd_sequencer.sv | 74 +++++++
 2 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command, ALU-drive and result buses of the sequencer; master = environment, slave = sequencer
interface alu_cmd_sequencer_if #(parameter int CNT_W = 8);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_key;
    logic [3:0]       cmd_a;
    logic [3:0]       cmd_b;
    logic             cmd_chain;
    logic [2:0]       alu_key;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [7:0]       alu_result;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_data;
    logic [2:0]       res_key;
    logic [CNT_W-1:0] op_count;
    logic             busy;
    modport slave (
        input  cmd_valid, cmd_key, cmd_a, cmd_b, cmd_chain, alu_result, res_ready,
        output cmd_ready, alu_key, alu_a, alu_b, res_valid, res_data, res_key, op_count, busy
    );
    modport master (
        output cmd_valid, cmd_key, cmd_a, cmd_b, cmd_chain, alu_result, res_ready,
        input  cmd_ready, alu_key, alu_a, alu_b, res_valid, res_data, res_key, op_count, busy
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: IDLE/EXEC/DONE sequencer; ports clock, reset, bus (cmd in, registered ALU drive, result out, op_count, busy)
module alu_cmd_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    alu_cmd_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t           state_q, state_d;
    logic [2:0]       alu_key_q, alu_key_d, res_key_q, res_key_d;
    logic [3:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [7:0]       res_data_q, res_data_d, last_res_q, last_res_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    always_comb begin
        state_d    = state_q;
        alu_key_d  = alu_key_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        res_data_d = res_data_q;
        res_key_d  = res_key_q;
        last_res_d = last_res_q;
        op_count_d = op_count_q;
        unique case (state_q)
            IDLE: if (bus.cmd_valid) begin
                alu_key_d = bus.cmd_key;
                alu_a_d   = bus.cmd_a;
                alu_b_d   = bus.cmd_chain ? last_res_q[3:0] : bus.cmd_b;
                state_d   = EXEC;
            end
            EXEC: begin
                res_data_d = bus.alu_result;
                res_key_d  = alu_key_q;
                last_res_d = bus.alu_result;
                state_d    = DONE;
            end
            DONE: if (bus.res_ready) begin
                op_count_d = op_count_q + 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            alu_key_q  <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            res_data_q <= '0;
            res_key_q  <= '0;
            last_res_q <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            alu_key_q  <= alu_key_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            res_data_q <= res_data_d;
            res_key_q  <= res_key_d;
            last_res_q <= last_res_d;
            op_count_q <= op_count_d;
        end
    end
    assign bus.cmd_ready = state_q == IDLE;
    assign bus.res_valid = state_q == DONE;
    assign bus.busy      = state_q != IDLE;
    assign bus.alu_key   = alu_key_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_key   = res_key_q;
    assign bus.op_count  = op_count_q;
endmodule
